// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified 32-bit memory: round-robin grant, registered
// memory strobes and a programmable LATENCY-cycle access window per transaction.
//   state  | meaning
//   IDLE   | strobes low; arbitrate pending requests at the clock edge
//   ACCESS | LATENCY cycles presenting the latched transaction to memory
//   RESP   | one-cycle ack to the owner; memory address held

module mem_port_arbiter #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic [31:0] rdata0,
   output logic        ack0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic [31:0] rdata1,
   output logic        ack1,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        winner;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         owner_q  <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      // owner_q doubles as the last-granted port; a tie goes to the other one
      winner   = (req0 && req1) ? ~owner_q : req1;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = ACCESS;
               owner_d = winner;
               cnt_d   = CNT_LOAD;
               we_d    = winner ? we1    : we0;
               addr_d  = winner ? addr1  : addr0;
               wdata_d = winner ? wdata1 : wdata0;
               rd_d    = ~we_d;
               wr_d    = we_d;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               if (!we_q) begin
                  if (owner_q) rdata1_d = mem_rdata;
                  else         rdata0_d = mem_rdata;
               end
               ack0_d = ~owner_q;
               ack1_d = owner_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
               rd_d  = ~we_q;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_read  = rd_q;
   assign mem_write = wr_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized two-master bench for mem_port_arbiter (LATENCY=3) with a grant/memory scoreboard,
// plus a short directed sequence on a LATENCY=1 instance.
module tb_mem_port_arbiter;

   localparam int L = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] ram_init(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   // ---------------- main DUT (LATENCY = 3) ----------------
   logic        rst;
   logic [1:0]  req, we, ack;
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, busy, owner;
   logic        init_ram;
   logic [31:0] ram [16];

   mem_port_arbiter #(.LATENCY(L)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .rdata0(rdata[0]), .ack0(ack[0]),
      .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .rdata1(rdata[1]), .ack1(ack[1]),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner));

   always @(posedge clk) begin
      if (init_ram) begin
         for (int i = 0; i < 16; i++) ram[i] <= ram_init(i);
      end else if (mem_write) begin
         ram[mem_addr[5:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_read ? ram[mem_addr[5:2]] : 32'hBAD0_BAD0;

   // ---------------- reference model + monitor ----------------
   typedef struct {
      int          port;
      int          grant_cyc;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   txn_t        expq [$];
   int          cyc;
   int          free_cyc;
   bit          last_own;
   bit          started;
   logic [31:0] model_mem [16];
   logic [31:0] hold [2];

   initial begin
      int   w;
      int   k;
      bit   act;
      txn_t t;
      txn_t h;
      cyc = 0; free_cyc = 0; last_own = 1'b1; started = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            expq.delete();
            free_cyc = cyc + 1;
            last_own = 1'b1;
            hold[0]  = 32'd0;
            hold[1]  = 32'd0;
            if (!started) for (int i = 0; i < 16; i++) model_mem[i] = ram_init(i);
            started = 1'b1;
         end else if (started && cyc >= free_cyc && (req[0] || req[1])) begin
            // memory is free: pick a requester, the memory effect happens now in program order
            w = (req[0] && req[1]) ? (last_own ? 0 : 1) : (req[1] ? 1 : 0);
            t.port = w; t.grant_cyc = cyc; t.we = we[w];
            t.addr = addr[w]; t.wdata = wdata[w];
            t.rdata = t.we ? 32'd0 : model_mem[t.addr[5:2]];
            if (t.we) model_mem[t.addr[5:2]] = t.wdata;
            expq.push_back(t);
            last_own = (w == 1);
            free_cyc = cyc + L + 2;
         end
         cyc++;

         @(negedge clk);
         if (started) begin
            act = 1'b0; k = 0;
            if (expq.size() > 0) begin
               h = expq[0];
               k = cyc - h.grant_cyc;
               act = (k >= 1 && k <= L + 1);
            end
            chk("busy", busy, act);
            chk("mem_read", mem_read, act && k <= L && !h.we);
            chk("mem_write", mem_write, act && k == 1 && h.we);
            chk("ack0", ack[0], act && k == L + 1 && h.port == 0);
            chk("ack1", ack[1], act && k == L + 1 && h.port == 1);
            chk("owner", owner, last_own);
            if (act) begin
               chk("mem_addr", mem_addr, h.addr);
               chk("mem_wdata", mem_wdata, h.wdata);
            end
            if (act && k == L + 1) begin
               if (!h.we) hold[h.port] = h.rdata;
               void'(expq.pop_front());
            end
            chk("rdata0", rdata[0], hold[0]);
            chk("rdata1", rdata[1], hold[1]);
         end
      end
   end

   // ---------------- stimulus ----------------
   int prob;
   int done [2];
   int wcnt [2];

   task automatic new_txn(input int p);
      logic [31:0] r;
      r = $urandom;
      req[p]   = 1'b1;
      we[p]    = 1'($urandom_range(1));
      addr[p]  = r & 32'hFFFF_FFFC;
      wdata[p] = $urandom;
   endtask

   task automatic step_port(input int p);
      if (req[p]) begin
         if (ack[p]) begin
            done[p]++;
            wcnt[p] = 0;
            if (int'($urandom_range(99)) < prob) new_txn(p);
            else req[p] = 1'b0;
         end else begin
            wcnt[p]++;
            // fields changing after the grant must not reach memory
            if (busy && owner == (p == 1) && $urandom_range(3) == 0) begin
               addr[p]  = $urandom & 32'hFFFF_FFFC;
               wdata[p] = $urandom;
               we[p]    = ~we[p];
            end
            if (wcnt[p] > 100) begin
               chk(p == 0 ? "ack0_timeout" : "ack1_timeout", 32'(wcnt[p]), 32'd0);
               req[p]  = 1'b0;
               wcnt[p] = 0;
            end
         end
      end else if (int'($urandom_range(99)) < prob) begin
         new_txn(p);
      end
   endtask

   initial begin
      int run;
      int rst_inj;
      rst = 1'b1; init_ram = 1'b1; prob = 0; req = 2'b00; we = 2'b00;
      addr[0] = 32'd0; addr[1] = 32'd0; wdata[0] = 32'd0; wdata[1] = 32'd0;
      done[0] = 0; done[1] = 0; wcnt[0] = 0; wcnt[1] = 0;
      run = 0; rst_inj = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0; init_ram = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         prob = (n < 80 || n >= 1800) ? 100 : 45;
         run  = busy ? run + 1 : 0;
         if (rst) begin
            rst = 1'b0;
         end else if (run == 2 && ((rst_inj == 0 && n >= 40) || (rst_inj == 1 && n >= 1000))) begin
            // reset lands on the edge ending the second ACCESS cycle
            rst = 1'b1;
            rst_inj++;
         end
         step_port(0);
         step_port(1);
      end
      chk("reset_injections", 32'(rst_inj), 32'd2);
      chk("port0_progress", 32'(done[0] >= 20), 32'd1);
      chk("port1_progress", 32'(done[1] >= 20), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- directed LATENCY = 1 instance ----------------
   logic        s_rst, s_req0, s_we0, s_ack0, s_req1, s_we1, s_ack1;
   logic [31:0] s_addr0, s_wdata0, s_rdata0, s_addr1, s_wdata1, s_rdata1;
   logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
   logic        s_mem_read, s_mem_write, s_busy, s_owner;

   mem_port_arbiter #(.LATENCY(1)) u_l1 (
      .clk(clk), .rst(s_rst),
      .req0(s_req0), .we0(s_we0), .addr0(s_addr0), .wdata0(s_wdata0), .rdata0(s_rdata0), .ack0(s_ack0),
      .req1(s_req1), .we1(s_we1), .addr1(s_addr1), .wdata1(s_wdata1), .rdata1(s_rdata1), .ack1(s_ack1),
      .mem_addr(s_mem_addr), .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_wdata(s_mem_wdata),
      .mem_rdata(s_mem_rdata), .busy(s_busy), .owner(s_owner));

   assign s_mem_rdata = s_mem_read ? 32'hDEAD_BEEF : 32'h0;

   initial begin
      s_rst = 1'b1; s_req0 = 1'b0; s_req1 = 1'b0; s_we0 = 1'b0; s_we1 = 1'b0;
      s_addr0 = 32'd0; s_addr1 = 32'd0; s_wdata0 = 32'd0; s_wdata1 = 32'd0;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      chk("l1_reset_busy", s_busy, 0);
      chk("l1_reset_owner", s_owner, 1);
      chk("l1_reset_rdata0", s_rdata0, 0);
      chk("l1_reset_mem_addr", s_mem_addr, 0);
      s_req0 = 1'b1; s_addr0 = 32'h10;
      @(negedge clk);
      chk("l1_rd_strobe", s_mem_read, 1);
      chk("l1_rd_addr", s_mem_addr, 32'h10);
      chk("l1_rd_early_ack", s_ack0, 0);
      @(negedge clk);
      chk("l1_rd_ack0", s_ack0, 1);
      chk("l1_rd_rdata0", s_rdata0, 32'hDEAD_BEEF);
      chk("l1_rd_strobe_off", s_mem_read, 0);
      s_req0 = 1'b0;
      @(negedge clk);
      chk("l1_idle_busy", s_busy, 0);
      chk("l1_idle_ack0", s_ack0, 0);
      s_req1 = 1'b1; s_we1 = 1'b1; s_addr1 = 32'h40; s_wdata1 = 32'h1234_5678;
      @(negedge clk);
      chk("l1_wr_strobe", s_mem_write, 1);
      chk("l1_wr_data", s_mem_wdata, 32'h1234_5678);
      chk("l1_wr_addr", s_mem_addr, 32'h40);
      @(negedge clk);
      chk("l1_wr_ack1", s_ack1, 1);
      chk("l1_wr_rdata1", s_rdata1, 0);
      chk("l1_wr_rdata0_kept", s_rdata0, 32'hDEAD_BEEF);
      s_req1 = 1'b0; s_we1 = 1'b0;
      @(negedge clk);
      s_req0 = 1'b1; s_addr0 = 32'h80; s_req1 = 1'b1; s_addr1 = 32'hC0;
      @(negedge clk);
      chk("l1_tie_addr", s_mem_addr, 32'h80);
      chk("l1_tie_owner", s_owner, 0);
      @(negedge clk);
      chk("l1_tie_ack0", s_ack0, 1);
      chk("l1_tie_no_ack1", s_ack1, 0);
      s_req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("l1_second_addr", s_mem_addr, 32'hC0);
      @(negedge clk);
      chk("l1_second_ack1", s_ack1, 1);
      chk("l1_second_rdata1", s_rdata1, 32'hDEAD_BEEF);
      s_req1 = 1'b0;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single 32-bit unified memory (Ram32b) between two requesters.
- Port 0 is the multi-cycle CPU's instruction/data access. Port 1 is a secondary master: program loader, debug reader or DMA.
- Provides a req/ack handshake, round-robin fairness and a programmable memory access latency, so the CPU stalls cleanly while the other master owns memory.

Parameters:
LATENCY, 1, memory access cycles per transaction; legal range 1..15; held in a 4-bit down-counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req0  input  1  port 0 (CPU) request; held high until ack0
we0  input  1  port 0 write enable (1=write, 0=read); stable while req0
addr0  input  32  port 0 byte address; stable while req0
wdata0  input  32  port 0 write data; stable while req0
rdata0  output  32  port 0 read data; valid in the ack0 cycle, held until the next port 0 read completes
ack0  output  1  port 0 completion pulse, one cycle
req1, we1, addr1, wdata1, rdata1, ack1  (same directions/widths/meanings for port 1)
mem_addr  output  32  memory address
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid by the last access cycle
busy  output  1  high in ACCESS and RESP states
owner  output  1  port currently or most recently granted

Behaviour:
- Reset (synchronous, any state, including mid-transaction):
  - state=IDLE; ack0=ack1=0; mem_read=mem_write=0; mem_addr=0; mem_wdata=0.
  - rdata0=rdata1=0; busy=0; counter=0; last_owner=1; owner=1.
  - A write already strobed is not undone.
- States: IDLE, ACCESS, RESP. Registered outputs only; there are no combinational paths from req to memory.
- IDLE:
  - Memory strobes low.
  - At the clock edge, if any req is high, grant it and go to ACCESS.
  - If both are high, grant the port != last_owner.
  - Grant actions: latch addr/we/wdata of the winner into internal registers; owner=winner; last_owner=winner; counter=LATENCY-1.
- ACCESS (exactly LATENCY cycles):
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - Read: mem_read=1 for all LATENCY cycles.
  - Write: mem_write=1 only in the first ACCESS cycle, low thereafter.
  - counter decrements each cycle. On the edge with counter==0, capture mem_rdata into the winner's rdata (reads only), then go to RESP.
- RESP (1 cycle):
  - ack of the owner is high; strobes low; mem_addr holds.
  - Next state is always IDLE.
- Timing:
  - req first high in IDLE cycle c gives ACCESS in cycles c+1..c+LATENCY and ack in cycle c+LATENCY+1.
  - req-to-ack latency is LATENCY+1 cycles; minimum is 2.
  - Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Handshake rules:
  - A requester deasserts req at the edge ending its ack cycle. A req still high in the following IDLE cycle is a new transaction.
  - Requests arriving during ACCESS/RESP wait; they are never dropped.
  - addr/we/wdata changes after grant are ignored.
- Fairness:
  - With both ports continuously requesting, grants alternate 0,1,0,1...
  - The first tie after reset goes to port 0.
- rdata of a port is unchanged by writes and by the other port's transactions.
- ack0 and ack1 are never high together. ack is never high for a port that was not granted.

Test Plan:
- LATENCY=1: req0 read addr 0x0000_0010, memory returns 0xDEAD_BEEF -> mem_read high for 1 cycle with mem_addr=0x10; ack0 two cycles after req0 rises; rdata0=0xDEADBEEF.
- LATENCY=3: req1 write addr 0x40, data 0x1234_5678 -> mem_write high exactly 1 cycle with mem_wdata=0x12345678; ack1 at cycle +4; rdata1 unchanged (0).
- Both req0 and req1 rise together after reset, then each re-requests immediately after its ack -> grant order 0,1,0,1; owner toggles; no overlapping acks.
- req1 arrives during a port 0 ACCESS -> port 1 granted in the IDLE cycle after ack0; port 1's addr appears on mem_addr only after ack0.
- rst asserted in the second ACCESS cycle with LATENCY=3 -> next cycle state=IDLE, strobes 0, acks 0, rdata0/1=0; a subsequent tie grants port 0.
- addr0 changed from 0x10 to 0x20 mid-ACCESS -> mem_addr stays 0x10 until RESP completes.
